// File: rtl/uart_tx_buffered_if.sv
// Byte-offer handshake and serial line status between game logic and the UART transmitter.
interface uart_tx_buffered_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       ready;
    logic       tx_out;
    logic       busy;

    modport master (output data_in, data_valid, input ready, tx_out, busy);
    modport slave  (input data_in, data_valid, output ready, tx_out, busy);
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: start, 8 data bits LSB first, optional even parity, STOP_BITS stop bits.
// Define PARITY_EN to include the parity bit; the default build sends 8N1/8N2 frames.
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic i_clk,
    input  logic i_reset,
    uart_tx_buffered_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA,
`ifdef PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        r_state, w_next;
    logic [7:0]    r_hold, r_shift;
    logic          r_hold_full;
    logic [CW-1:0] r_baud;
    logic [2:0]    r_bit_cnt;
    logic          r_tx;
    logic          w_tick, w_last_stop, w_load, w_cap, w_tx;

    assign w_tick      = (r_state != IDLE) && (r_baud == CW'(CLKS_PER_BIT - 1));
    assign w_last_stop = (r_bit_cnt == 3'(STOP_BITS - 1));
    assign w_cap       = bus.data_valid && !r_hold_full;

    assign bus.ready  = !r_hold_full;
    assign bus.busy   = (r_state != IDLE) || r_hold_full;
    assign bus.tx_out = r_tx;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= IDLE;
            r_tx      <= 1'b1;
            r_baud    <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_state <= w_next;
            r_tx    <= w_tx;
            r_baud  <= (r_state == IDLE || w_tick) ? '0 : r_baud + 1'b1;
            if (w_tick) begin
                case (r_state)
                    DATA:    r_bit_cnt <= r_bit_cnt + 3'd1;
                    STOP:    r_bit_cnt <= w_last_stop ? 3'd0 : r_bit_cnt + 3'd1;
                    default: r_bit_cnt <= r_bit_cnt;
                endcase
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   if (r_hold_full) w_next = START;
            START:  if (w_tick) w_next = DATA;
            DATA:   if (w_tick && r_bit_cnt == 3'd7)
`ifdef PARITY_EN
                        w_next = PARITY;
            PARITY: if (w_tick) w_next = STOP;
`else
                        w_next = STOP;
`endif
            // Holding byte goes straight into the next start bit: no idle gap.
            STOP:   if (w_tick && w_last_stop) w_next = r_hold_full ? START : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_tx   = 1'b1;
        w_load = 1'b0;
        case (r_state)
            IDLE:   w_load = r_hold_full;
            START:  w_tx = 1'b0;
            DATA:   w_tx = r_shift[r_bit_cnt];
`ifdef PARITY_EN
            PARITY: w_tx = ^r_shift;
`endif
            STOP:   w_load = r_hold_full && w_tick && w_last_stop;
            default: w_tx = 1'b1;
        endcase
    end

    // Capture and load never coincide: capture needs the holding register empty, load needs it full.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
        end else begin
            if (w_load) r_shift <= r_hold;
            if (w_cap) begin
                r_hold      <= bus.data_in;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered at CLKS_PER_BIT=4, one stop bit.
module tb_uart_tx_buffered;
    localparam int CPB = 4;
`ifdef PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    uart_tx_buffered_if bus ();

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Offer b, check capture and the idle-to-start latency; returns at the negedge after the load edge.
    task automatic start_byte(input logic [7:0] b);
        @(negedge clk);
        bus.data_valid = 1'b1;
        bus.data_in    = b;
        @(negedge clk);
        chk("cap_ready", bus.ready, 1'b0);
        chk("cap_busy", bus.busy, 1'b1);
        chk("cap_tx", bus.tx_out, 1'b1);
        bus.data_valid = 1'b0;
        @(negedge clk);
        chk("load_tx", bus.tx_out, 1'b1);
        chk("load_ready", bus.ready, 1'b1);
    endtask

    // Checks every cycle of one frame on tx_out; ready is expected low for the first rdy_lo cycles.
    task automatic run_frame(input logic [7:0] b, input int rdy_lo, input bit churn);
        for (int c = 0; c < NB*CPB; c++) begin
            @(negedge clk);
            chk($sformatf("tx_%0h_c%0d", b, c), bus.tx_out, exp_bit(b, c / CPB));
            chk($sformatf("rdy_%0h_c%0d", b, c), bus.ready, (c < rdy_lo) ? 1'b0 : 1'b1);
            if (!churn && c == 0) bus.data_valid = 1'b0;
            if (churn) bus.data_in = bus.data_in + 8'h11;
            if (c == NB*CPB-2) bus.data_valid = 1'b0;
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, bus.busy, 1'b0);
        chk({tag, "_ready"}, bus.ready, 1'b1);
        chk({tag, "_tx"}, bus.tx_out, 1'b1);
    endtask

    initial begin
        // Reset held with a byte on offer: nothing captured.
        reset          = 1'b0;
        bus.data_valid = 1'b1;
        bus.data_in    = 8'hFF;
        repeat (3) @(negedge clk);
        chk_idle("rst");
        reset = 1'b1;
        #1;
        chk_idle("rel");
        @(negedge clk);
        chk("rel_cap_ready", bus.ready, 1'b0);
        bus.data_valid = 1'b0;
        @(negedge clk);
        chk("rel_load_tx", bus.tx_out, 1'b1);
        run_frame(8'hFF, 0, 1'b0);
        chk_idle("ff_end");

        // Single byte with exact bit timing.
        start_byte(8'hA5);
        run_frame(8'hA5, 0, 1'b0);
        chk_idle("a5_end");

        // Second byte offered while ready: back-to-back frames.
        start_byte(8'h3C);
        bus.data_valid = 1'b1;
        bus.data_in    = 8'hC3;
        run_frame(8'h3C, NB*CPB-1, 1'b0);
        run_frame(8'hC3, 0, 1'b0);
        chk_idle("c3_end");

        // data_valid held with changing data while full: only captured bytes go out.
        start_byte(8'h5A);
        bus.data_valid = 1'b1;
        bus.data_in    = 8'h96;
        run_frame(8'h5A, NB*CPB-1, 1'b1);
        run_frame(8'h96, 0, 1'b0);
        chk_idle("96_end");

`ifdef PARITY_EN
        start_byte(8'h07);
        run_frame(8'h07, 0, 1'b0);
        start_byte(8'h03);
        run_frame(8'h03, 0, 1'b0);
        chk_idle("par_end");
`endif

        // Reset mid-DATA: line returns high immediately, next byte is a clean frame.
        start_byte(8'h00);
        repeat (10) @(negedge clk);
        chk("mid_tx", bus.tx_out, 1'b0);
        chk("mid_busy", bus.busy, 1'b1);
        reset = 1'b0;
        #1;
        chk_idle("abort");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_idle("post_abort");
        start_byte(8'hA5);
        run_frame(8'hA5, 0, 1'b0);
        chk_idle("fresh_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
